imem_responder: RTL and testbench

Instruction-memory responder for the pipeline processor: accepts fetch requests carrying the 20-bit fetch address driven by the PC stage, reads a synchronous on-chip instruction RAM and returns instruction words in order to the decode stage through a 4-entry output queue. It implements the memory side of the fetch interface, drops in-flight and queued words on a jump, and provides a load port for writing the program image.

---
 rtl/imem_responder.sv | 141 ++++++++++++++
 tb/tb_imem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: synchronous RAM read stage feeding a 4-entry in-order queue toward decode.
// Optional IMEM_ADDR_CHECK_EN: out-of-range fetches return NOP and raise a sticky addrError; out-of-range loads are dropped.
module imem_responder #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetchAddress,
  input  logic              fetchValid,
  output logic              fetchReady,
  input  logic              flush,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instrAddress,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              loadEnable,
  input  logic [ADDR_W-1:0] loadAddress,
  input  logic [DATA_W-1:0] loadData
`ifdef IMEM_ADDR_CHECK_EN
  ,
  output logic              addrError
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_ld_idx;
  logic                  w_ld_we;
  logic                  w_fetch_oor;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [2:0]            w_occupancy;

  logic [DATA_W-1:0]     r_rd_data_p0;
  logic [ADDR_W-1:0]     r_rd_addr_p0;
  logic                  r_oor_p0;
  logic                  r_vld_p0;

  logic [DATA_W-1:0]     r_q_data_p1 [4];
  logic [ADDR_W-1:0]     r_q_addr_p1 [4];
  logic [1:0]            r_wr_ptr_p1;
  logic [1:0]            r_rd_ptr_p1;
  logic [2:0]            r_count_p1;

  assign w_rd_idx = fetchAddress[DEPTH_LOG2-1:0];
  assign w_ld_idx = loadAddress[DEPTH_LOG2-1:0];

`ifdef IMEM_ADDR_CHECK_EN
  logic r_addr_err;

  assign w_fetch_oor = |fetchAddress[ADDR_W-1:DEPTH_LOG2];
  assign w_ld_we     = loadEnable && !(|loadAddress[ADDR_W-1:DEPTH_LOG2]);
  assign addrError   = r_addr_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr_err <= 1'b0;
    end else if (w_accept && w_fetch_oor) begin
      r_addr_err <= 1'b1;
    end
  end
`else
  logic w_unused_ld_hi;

  // Upper load-address bits alias away when range checking is disabled.
  assign w_fetch_oor    = 1'b0;
  assign w_ld_we        = loadEnable;
  assign w_unused_ld_hi = ^loadAddress[ADDR_W-1:DEPTH_LOG2];
`endif

  // Counting the in-flight word keeps a free slot for whatever arrives next, so the queue never overflows.
  assign w_occupancy = r_count_p1 + {2'b00, r_vld_p0};
  assign fetchReady  = !flush && (w_occupancy <= 3'd2);
  assign w_accept    = fetchValid && fetchReady;

  // Stage 0: RAM read; a same-edge load leaves the read with the old word.
  always_ff @(posedge clock) begin
    if (w_ld_we) begin
      r_mem[w_ld_idx] <= loadData;
    end
    if (w_accept) begin
      r_rd_data_p0 <= r_mem[w_rd_idx];
      r_rd_addr_p0 <= fetchAddress;
      r_oor_p0     <= w_fetch_oor;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept;
    end
  end

  // Stage 1: circular output queue; flush discards in-flight and queued words alike.
  assign w_push = r_vld_p0 && !flush;
  assign w_pop  = instrValid && instrReady && !flush;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_data_p1[r_wr_ptr_p1] <= r_oor_p0 ? '0 : r_rd_data_p0;
      r_q_addr_p1[r_wr_ptr_p1] <= r_rd_addr_p0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr_p1 <= 2'd0;
      r_rd_ptr_p1 <= 2'd0;
      r_count_p1  <= 3'd0;
    end else if (flush) begin
      r_wr_ptr_p1 <= 2'd0;
      r_rd_ptr_p1 <= 2'd0;
      r_count_p1  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr_p1 <= r_wr_ptr_p1 + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr_p1 <= r_rd_ptr_p1 + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count_p1 <= r_count_p1 + 3'd1;
        2'b01:   r_count_p1 <= r_count_p1 - 3'd1;
        default: r_count_p1 <= r_count_p1;
      endcase
    end
  end

  // Head is forced to zero when empty so outputs read as zero straight out of reset.
  assign instrValid   = (r_count_p1 != 3'd0);
  assign instruction  = instrValid ? r_q_data_p1[r_rd_ptr_p1] : '0;
  assign instrAddress = instrValid ? r_q_addr_p1[r_rd_ptr_p1] : '0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a transaction-level model predicts acceptance and the returned word stream.
module tb_imem_responder;

  logic        clk;
  logic        rst_n;
  logic [19:0] fetchAddress;
  logic        fetchValid;
  logic        fetchReady;
  logic        flush;
  logic [31:0] instruction;
  logic [19:0] instrAddress;
  logic        instrValid;
  logic        instrReady;
  logic        loadEnable;
  logic [19:0] loadAddress;
  logic [31:0] loadData;
`ifdef IMEM_ADDR_CHECK_EN
  logic        addrError;
`endif

  imem_responder #(.ADDR_W(20), .DATA_W(32), .DEPTH_LOG2(10)) dut (
    .clock        (clk),
    .reset        (rst_n),
    .fetchAddress (fetchAddress),
    .fetchValid   (fetchValid),
    .fetchReady   (fetchReady),
    .flush        (flush),
    .instruction  (instruction),
    .instrAddress (instrAddress),
    .instrValid   (instrValid),
    .instrReady   (instrReady),
    .loadEnable   (loadEnable),
    .loadAddress  (loadAddress),
    .loadData     (loadData)
`ifdef IMEM_ADDR_CHECK_EN
    ,
    .addrError    (addrError)
`endif
  );

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mem [1024];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          rst_active = 1'b1;
  logic        exp_err = 1'b0;
  logic        err_pend = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d required=completion", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_oor(input logic [19:0] a);
`ifdef IMEM_ADDR_CHECK_EN
    return a[19:10] != 10'd0;
`else
    return 1'b0;
`endif
  endfunction

  // One bus cycle: drive inputs, predict acceptance, record the expected word, apply the load.
  task automatic cycle(input logic v, input logic [19:0] a, input logic fl, input logic rd,
                       input logic le, input logic [19:0] la, input logic [31:0] ld);
    exp_t e;
    logic exp_rdy;
    @(negedge clk);
    fetchValid = v; fetchAddress = a; flush = fl; instrReady = rd;
    loadEnable = le; loadAddress = la; loadData = ld;
    #1;
    exp_err  = exp_err | err_pend;
    err_pend = 1'b0;
    exp_rdy  = !fl && (sb.size() <= 2);
    chk("fetchReady", {63'd0, fetchReady}, {63'd0, exp_rdy});
    if (v && exp_rdy) begin
      e.addr = a;
      e.cyc  = cyc;
      if (is_oor(a)) begin
        e.data   = 32'd0;
        err_pend = 1'b1;
      end else begin
        e.data = m_mem[a[9:0]];
      end
      sb.push_back(e);
    end
    if (le && !is_oor(la)) m_mem[la[9:0]] = ld;
  endtask

  task automatic idle(input int n, input logic rd);
    for (int k = 0; k < n; k++) cycle(1'b0, 20'd0, 1'b0, rd, 1'b0, 20'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_active = 1'b1;
    rst_n = 1'b0;
    fetchValid = 1'b0; flush = 1'b0; instrReady = 1'b0; loadEnable = 1'b0;
    #1;
    chk("rst_instrValid", {63'd0, instrValid}, 64'd0);
    chk("rst_fetchReady", {63'd0, fetchReady}, 64'd1);
    chk("rst_instruction", {32'd0, instruction}, 64'd0);
    chk("rst_instrAddress", {44'd0, instrAddress}, 64'd0);
`ifdef IMEM_ADDR_CHECK_EN
    chk("rst_addrError", {63'd0, addrError}, 64'd0);
`endif
    sb.delete();
    exp_err  = 1'b0;
    err_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rst_active = 1'b0;
  endtask

  // Monitor: compares the head against the oldest outstanding word whenever it should be visible.
  initial begin
    logic exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_active) begin
        exp_v = (sb.size() > 0) && (cyc >= sb[0].cyc + 2);
        chk("instrValid", {63'd0, instrValid}, {63'd0, exp_v});
        if (exp_v && instrValid) begin
          chk("instruction", {32'd0, instruction}, {32'd0, sb[0].data});
          chk("instrAddress", {44'd0, instrAddress}, {44'd0, sb[0].addr});
        end
`ifdef IMEM_ADDR_CHECK_EN
        chk("addrError", {63'd0, addrError}, {63'd0, exp_err});
`endif
        if (flush) sb.delete();
        else if (exp_v && instrReady) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    fetchValid = 1'b0; fetchAddress = '0; flush = 1'b0; instrReady = 1'b0;
    loadEnable = 1'b0; loadAddress = '0; loadData = '0;
    do_reset();

    for (int i = 0; i < 1024; i++) cycle(1'b0, 20'd0, 1'b0, 1'b1, 1'b1, 20'(i), $urandom);
    for (int i = 0; i < 8; i++) cycle(1'b0, 20'd0, 1'b0, 1'b1, 1'b1, 20'(i), 32'hA000_0000 + i);

    // Streaming
    for (int i = 0; i < 8; i++) cycle(1'b1, 20'(i), 1'b0, 1'b1, 1'b0, 20'd0, 32'd0);
    idle(4, 1'b1);

    // Backpressure
    for (int i = 0; i < 4; i++) cycle(1'b1, 20'(i), 1'b0, 1'b0, 1'b0, 20'd0, 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 20'd3, 1'b0, 1'b0, 1'b0, 20'd0, 32'd0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 20'd3, 1'b0, 1'b1, 1'b0, 20'd0, 32'd0);
    idle(6, 1'b1);

    // Flush with three words queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 20'(10 + i), 1'b0, 1'b0, 1'b0, 20'd0, 32'd0);
    idle(2, 1'b0);
    cycle(1'b1, 20'd5, 1'b1, 1'b0, 1'b0, 20'd0, 32'd0);
    cycle(1'b1, 20'h40, 1'b0, 1'b1, 1'b0, 20'd0, 32'd0);
    idle(4, 1'b1);

    // Read/write collision then refetch
    cycle(1'b1, 20'd3, 1'b0, 1'b1, 1'b1, 20'd3, 32'h0000_DEAD);
    idle(1, 1'b1);
    cycle(1'b1, 20'd3, 1'b0, 1'b1, 1'b0, 20'd0, 32'd0);
    idle(3, 1'b1);

    // Address range
    cycle(1'b1, 20'h00400, 1'b0, 1'b1, 1'b0, 20'd0, 32'd0);
    idle(3, 1'b1);

    // Reset with a full queue, then refetch
    for (int i = 0; i < 5; i++) cycle(1'b1, 20'(i), 1'b0, 1'b0, 1'b0, 20'd0, 32'd0);
    do_reset();
    cycle(1'b1, 20'd3, 1'b0, 1'b1, 1'b0, 20'd0, 32'd0);
    cycle(1'b1, 20'd7, 1'b0, 1'b1, 1'b0, 20'd0, 32'd0);
    idle(4, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [19:0] a;
      logic [19:0] la;
      a  = ($urandom % 4 == 0) ? 20'($urandom) : 20'($urandom % 16);
      la = ($urandom % 4 == 0) ? 20'($urandom) : 20'($urandom % 16);
      if ($urandom % 600 == 0) do_reset();
      cycle(($urandom % 4) != 0, a, ($urandom % 16) == 0, ($urandom % 3) != 0,
            ($urandom % 8) == 0, la, $urandom);
    end

    idle(8, 1'b1);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
